// File: rtl/nrisc_pkg.sv
// nrisc_pkg: shared definitions for the nRISC fetch stage.
//   PC_W          width of program addresses
//   RESET_PC_DEF  default first fetch address after reset
//   PC_MAX_DEF    default last valid program address
//   fetch_state_e fetch FSM encoding (RUN, HALT)
package nrisc_pkg;

    localparam int PC_W = 8;

    localparam logic [PC_W-1:0] RESET_PC_DEF = 8'h80;
    localparam logic [PC_W-1:0] PC_MAX_DEF   = 8'h99;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational branch-target computation and window check.
// Ports:
//   redirect_rel_i   1 = relative target, 0 = absolute target
//   redirect_addr_i  absolute target, or two's-complement offset
//   base_pc_i        address of the branch instruction being decoded
//   target_o         computed target address (modulo 2^PC_W)
//   out_of_range_o   target lies outside [RESET_PC, PC_MAX]
module pc_target_calc
    import nrisc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [PC_W-1:0] PC_MAX   = PC_MAX_DEF
) (
    input  logic            redirect_rel_i,
    input  logic [PC_W-1:0] redirect_addr_i,
    input  logic [PC_W-1:0] base_pc_i,
    output logic [PC_W-1:0] target_o,
    output logic            out_of_range_o
);

    // The offset is already PC_W bits wide, so sign extension to the
    // address width is the identity; a plain modulo add gives base + offset.
    always_comb begin
        if (redirect_rel_i) begin
            target_o = base_pc_i + redirect_addr_i;
        end else begin
            target_o = redirect_addr_i;
        end
        out_of_range_o = (target_o < RESET_PC) || (target_o > PC_MAX);
    end

endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and fetch control for the nRISC core.
// Drives the fetch address into a memory with a one-cycle registered read
// and tags each memory output with its address and a valid bit.
// Ports:
//   clock, reset          clock; synchronous active-low reset
//   stall                 decoder cannot accept an instruction this cycle
//   redirect              branch/jump taken this cycle
//   redirect_rel          1 = relative target, 0 = absolute
//   redirect_addr         absolute target or signed offset
//   PC                    fetch address to the instruction memory
//   fetch_valid           memory output this cycle is a live instruction
//   fetch_pc              address of the instruction on the memory output
//   halted                fetch has stopped (HALT state)
//   fault                 sticky: a redirect target left the program window
//   state_dbg             current FSM state
//
// Flow control: a fetch is issued on an edge when the FSM is in RUN and
// neither redirect nor stall is asserted; the memory output in the
// following cycle is then flagged with fetch_valid = 1 and tagged with the
// issued address in fetch_pc. Redirect wins over stall.
module pc_fetch
    import nrisc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [PC_W-1:0] PC_MAX   = PC_MAX_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic            redirect_rel,
    input  logic [PC_W-1:0] redirect_addr,
    output logic [PC_W-1:0] PC,
    output logic            fetch_valid,
    output logic [PC_W-1:0] fetch_pc,
    output logic            halted,
    output logic            fault,
    output fetch_state_e    state_dbg
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            fault_q, fault_d;
    logic            halted_q;
    fetch_state_e    state_q, state_d;

    logic [PC_W-1:0] tgt;
    logic            tgt_oor;

    // Relative targets are based on the branch being decoded, i.e. the
    // instruction currently tagged by fetch_pc, not on the fetch address.
    pc_target_calc #(
        .RESET_PC (RESET_PC),
        .PC_MAX   (PC_MAX)
    ) u_target (
        .redirect_rel_i  (redirect_rel),
        .redirect_addr_i (redirect_addr),
        .base_pc_i       (fetch_pc_q),
        .target_o        (tgt),
        .out_of_range_o  (tgt_oor)
    );

    always_comb begin
        pc_d          = pc_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = 1'b0;
        fault_d       = fault_q;
        state_d       = state_q;
        if (state_q == ST_RUN) begin
            if (redirect) begin
                // Wrong-path output next cycle is dropped (valid stays 0).
                if (tgt_oor) begin
                    state_d = ST_HALT;
                    fault_d = 1'b1;
                end else begin
                    pc_d = tgt;
                end
            end else if (!stall) begin
                fetch_valid_d = 1'b1;
                fetch_pc_d    = pc_q;
                // The last address is still issued; only the increment stops.
                if (pc_q == PC_MAX) begin
                    state_d = ST_HALT;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q          <= RESET_PC;
            fetch_pc_q    <= RESET_PC;
            fetch_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            halted_q      <= 1'b0;
            state_q       <= ST_RUN;
        end else begin
            pc_q          <= pc_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            fault_q       <= fault_d;
            halted_q      <= (state_d == ST_HALT);
            state_q       <= state_d;
        end
    end

    assign PC          = pc_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_valid = fetch_valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch with a registered-read memory
// model attached to PC. Each task drives one scenario and checks the packed
// output vector {PC, fetch_pc, fetch_valid, halted, fault} against
// hand-computed values.
module tb_pc_fetch;
    import nrisc_pkg::*;

    logic         clock;
    logic         reset;
    logic         stall;
    logic         redirect;
    logic         redirect_rel;
    logic [7:0]   redirect_addr;
    logic [7:0]   PC;
    logic         fetch_valid;
    logic [7:0]   fetch_pc;
    logic         halted;
    logic         fault;
    fetch_state_e state_dbg;

    logic [7:0]   mem_q;
    logic [18:0]  obs;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_rel  (redirect_rel),
        .redirect_addr (redirect_addr),
        .PC            (PC),
        .fetch_valid   (fetch_valid),
        .fetch_pc      (fetch_pc),
        .halted        (halted),
        .fault         (fault),
        .state_dbg     (state_dbg)
    );

    // clock / reset block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: one-cycle registered read, content = addr ^ 8'hA5.
    always @(posedge clock) mem_q <= PC ^ 8'hA5;

    assign obs = {PC, fetch_pc, fetch_valid, halted, fault};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_rel  = 1'b0;
        redirect_addr = 8'h00;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (obs !== {8'h80, 8'h80, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got %h expected %h", obs, {8'h80, 8'h80, 3'b000});
        end
        n_checks++;
        if (state_dbg !== ST_RUN) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", state_dbg, ST_RUN);
        end
    endtask

    task automatic test_free_run();
        logic [7:0] exp_pc;
        logic [7:0] exp_fpc;
        logic       exp_h;
        do_reset();
        for (int k = 1; k <= 26; k++) begin
            tick();
            exp_pc  = (k < 26) ? 8'h80 + 8'(k) : 8'h99;
            exp_fpc = 8'h7F + 8'(k);
            exp_h   = (k == 26);
            n_checks++;
            if (obs !== {exp_pc, exp_fpc, 1'b1, exp_h, 1'b0}) begin
                n_fail++;
                $display("FAIL free_run k=%0d: got %h expected %h", k, obs,
                         {exp_pc, exp_fpc, 1'b1, exp_h, 1'b0});
            end
            n_checks++;
            if (mem_q !== (exp_fpc ^ 8'hA5)) begin
                n_fail++;
                $display("FAIL free_run_instr k=%0d: got %h expected %h", k, mem_q, exp_fpc ^ 8'hA5);
            end
        end
        tick();
        n_checks++;
        if (obs !== {8'h99, 8'h99, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL free_run_halt: got %h expected %h", obs, {8'h99, 8'h99, 3'b010});
        end
        // Redirect and stall are ignored once halted.
        redirect      = 1'b1;
        redirect_addr = 8'h85;
        stall         = 1'b1;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        n_checks++;
        if (obs !== {8'h99, 8'h99, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL halt_ignores_redirect: got %h expected %h", obs, {8'h99, 8'h99, 3'b010});
        end
        n_checks++;
        if (state_dbg !== ST_HALT) begin
            n_fail++;
            $display("FAIL halt_state: got %0d expected %0d", state_dbg, ST_HALT);
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (5) tick();
        n_checks++;
        if (obs !== {8'h85, 8'h84, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_pre: got %h expected %h", obs, {8'h85, 8'h84, 3'b100});
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== {8'h85, 8'h84, 1'b0, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold i=%0d: got %h expected %h", i, obs, {8'h85, 8'h84, 3'b000});
            end
        end
        stall = 1'b0;
        tick();
        n_checks++;
        if (obs !== {8'h86, 8'h85, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_resume: got %h expected %h", obs, {8'h86, 8'h85, 3'b100});
        end
        tick();
        n_checks++;
        if (obs !== {8'h87, 8'h86, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stall_after: got %h expected %h", obs, {8'h87, 8'h86, 3'b100});
        end
    endtask

    task automatic test_rel_redirect();
        do_reset();
        repeat (15) tick();
        n_checks++;
        if (obs !== {8'h8F, 8'h8E, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rel_pre: got %h expected %h", obs, {8'h8F, 8'h8E, 3'b100});
        end
        redirect      = 1'b1;
        redirect_rel  = 1'b1;
        redirect_addr = 8'hFA;
        tick();
        redirect     = 1'b0;
        redirect_rel = 1'b0;
        n_checks++;
        if (obs !== {8'h88, 8'h8E, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rel_target: got %h expected %h", obs, {8'h88, 8'h8E, 3'b000});
        end
        tick();
        n_checks++;
        if (obs !== {8'h89, 8'h88, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rel_first_valid: got %h expected %h", obs, {8'h89, 8'h88, 3'b100});
        end
        tick();
        n_checks++;
        if (obs !== {8'h8A, 8'h89, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rel_next: got %h expected %h", obs, {8'h8A, 8'h89, 3'b100});
        end
    endtask

    task automatic test_abs_fault();
        do_reset();
        repeat (3) tick();
        redirect      = 1'b1;
        redirect_addr = 8'h20;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (obs !== {8'h83, 8'h82, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL fault_set: got %h expected %h", obs, {8'h83, 8'h82, 3'b011});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== {8'h83, 8'h82, 1'b0, 1'b1, 1'b1}) begin
                n_fail++;
                $display("FAIL fault_sticky i=%0d: got %h expected %h", i, obs, {8'h83, 8'h82, 3'b011});
            end
        end
        do_reset();
        n_checks++;
        if (obs !== {8'h80, 8'h80, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL fault_clear: got %h expected %h", obs, {8'h80, 8'h80, 3'b000});
        end
    endtask

    task automatic test_window_edges();
        // Absolute jump to PC_MAX is legal and halts after delivering it.
        do_reset();
        tick();
        redirect      = 1'b1;
        redirect_addr = 8'h99;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (obs !== {8'h99, 8'h80, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL edge_max_target: got %h expected %h", obs, {8'h99, 8'h80, 3'b000});
        end
        tick();
        n_checks++;
        if (obs !== {8'h99, 8'h99, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL edge_max_issue: got %h expected %h", obs, {8'h99, 8'h99, 3'b110});
        end
        // Just below the window.
        do_reset();
        tick();
        redirect      = 1'b1;
        redirect_addr = 8'h7F;
        tick();
        redirect = 1'b0;
        n_checks++;
        if (obs !== {8'h81, 8'h80, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL edge_below: got %h expected %h", obs, {8'h81, 8'h80, 3'b011});
        end
        // Relative: 0x80 + 0x19 = 0x99 in range, then 0x80 + 0x1A = 0x9A out.
        do_reset();
        tick();
        redirect      = 1'b1;
        redirect_rel  = 1'b1;
        redirect_addr = 8'h19;
        tick();
        n_checks++;
        if (obs !== {8'h99, 8'h80, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL edge_rel_in: got %h expected %h", obs, {8'h99, 8'h80, 3'b000});
        end
        redirect_addr = 8'h1A;
        tick();
        redirect     = 1'b0;
        redirect_rel = 1'b0;
        n_checks++;
        if (obs !== {8'h99, 8'h80, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL edge_rel_out: got %h expected %h", obs, {8'h99, 8'h80, 3'b011});
        end
    endtask

    task automatic test_redirect_stall();
        do_reset();
        repeat (2) tick();
        redirect      = 1'b1;
        stall         = 1'b1;
        redirect_addr = 8'h90;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        n_checks++;
        if (obs !== {8'h90, 8'h81, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_stall_target: got %h expected %h", obs, {8'h90, 8'h81, 3'b000});
        end
        tick();
        n_checks++;
        if (obs !== {8'h91, 8'h90, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_stall_valid: got %h expected %h", obs, {8'h91, 8'h90, 3'b100});
        end
    endtask

    // Continues from test_redirect_stall (PC = 0x91).
    task automatic test_reset_mid();
        repeat (2) tick();
        n_checks++;
        if (obs !== {8'h93, 8'h92, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_pre: got %h expected %h", obs, {8'h93, 8'h92, 3'b100});
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        n_checks++;
        if (obs !== {8'h80, 8'h80, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got %h expected %h", obs, {8'h80, 8'h80, 3'b000});
        end
        tick();
        n_checks++;
        if (obs !== {8'h81, 8'h80, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_resume1: got %h expected %h", obs, {8'h81, 8'h80, 3'b100});
        end
        tick();
        n_checks++;
        if (obs !== {8'h82, 8'h81, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_resume2: got %h expected %h", obs, {8'h82, 8'h81, 3'b100});
        end
    endtask

    initial begin
        reset         = 1'b0;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_rel  = 1'b0;
        redirect_addr = 8'h00;
        test_reset();
        test_free_run();
        test_stall();
        test_rel_redirect();
        test_abs_fault();
        test_window_edges();
        test_redirect_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and fetch-control stage of the 8-bit nRISC core, directly upstream of the instruction memory. It drives the fetch address into the memory, whose read port is registered with one cycle of latency. It tracks which address each memory output belongs to and flags valid instructions for the decoder. It also applies stalls and branch redirects, and stops fetching at the end of the program window.

## Interface
Parameters:
- `RESET_PC`, default 8'h80: first fetch address after reset.
- `PC_MAX`, default 8'h99: last valid program address. The program window is [RESET_PC, PC_MAX].

Ports:
- `clock`  in  1: single clock. All state changes on posedge.
- `reset`  in  1: synchronous, active-low. Sampled on posedge.
- `stall`  in  1: decoder cannot accept a new instruction. Hold fetch.
- `redirect`  in  1: branch or jump taken this cycle.
- `redirect_rel`  in  1: 1 = relative target, 0 = absolute target.
- `redirect_addr`  in  8: absolute target, or signed offset when relative.
- `PC`  out  8: fetch address to the instruction memory.
- `fetch_valid`  out  1: the memory output this cycle is a live instruction.
- `fetch_pc`  out  8: address of the instruction currently on the memory output.
- `halted`  out  1: fetch has stopped.
- `fault`  out  1: sticky flag. A redirect target fell outside the program window.

## Operation
- FSM has 2 states:
  - RUN (reset state)
  - HALT (exited only by reset)
- Issue condition: a fetch is *issued* in cycle t iff state = RUN, `redirect` = 0 and `stall` = 0.
- Issue effects:
  - `fetch_valid`(t+1) = issued(t).
  - On issue, `fetch_pc` ← `PC`.
- Next PC when in RUN:
  - redirect: PC ← target. Nothing is issued. The wrong-path memory output at t+1 is suppressed (`fetch_valid` = 0).
  - else if stall: PC holds.
  - else if PC == PC_MAX: PC holds and the state goes to HALT. This last instruction is still issued and delivered valid.
  - else: PC ← PC + 1.
- Target arithmetic, all 8-bit modulo 256:
  - absolute: target = `redirect_addr`.
  - relative: target = `fetch_pc` + `redirect_addr`, with `redirect_addr` read as two's complement. The base is the address of the branch instruction being decoded.
- Target outside [RESET_PC, PC_MAX]:
  - PC is not loaded.
  - State goes to HALT.
  - `fault` ← 1.
- Priority:
  - reset > redirect > stall > halt-at-end > increment.
  - `redirect` and `stall` asserted together: the redirect is taken and the stall is ignored for this cycle.
- In HALT:
  - PC holds and nothing is issued.
  - `halted` = 1.
  - `redirect` and `stall` are ignored.

## Timing
- Reset values, applied on the first posedge with `reset` = 0:
  - PC = RESET_PC, `fetch_pc` = RESET_PC
  - `fetch_valid` = 0, `halted` = 0, `fault` = 0
  - state = RUN
- Reset mid-operation aborts any in-flight fetch. `fetch_valid` is 0 in the cycle after the reset edge.
- Latency:
  - PC to valid instruction: 1 cycle, matching the memory's registered read.
  - Redirect to the first target instruction valid: 2 cycles.
  - One bubble per taken redirect.
- Stall has no combinational path to `PC`; it takes effect at the next edge. A stall of N cycles inserts N invalid cycles.
- All outputs are registered. There is no combinational input→output path.
- `halted` rises on the edge that enters HALT. If the last valid instruction is still in flight, it is presented with `fetch_valid` = 1 in the same cycle that `halted` first reads 1.

## Structure
- Shared package `nrisc_pkg` holds:
  - the RESET_PC and PC_MAX constants
  - the PC width (8)
  - the FSM state encoding (RUN, HALT)
- One sub-module, `pc_target_calc`: combinational target mux and sign-extending adder, plus the window range check. It outputs the target and an `out_of_range` flag.
- Registers live in the top level: PC, `fetch_pc`, `fetch_valid`, state, `fault`.

## Test plan
- Reset, then free-run with the memory attached. Required:
  - PC steps 0x80…0x99.
  - `fetch_valid` = 1 from cycle 2.
  - The instruction at 0x80 and `fetch_pc` = 0x80 appear together.
  - After 0x99 is delivered: `halted` = 1, PC holds at 0x99, `fetch_valid` drops to 0.
- Stall for 3 cycles at PC = 0x85. Required:
  - PC holds 0x85.
  - Exactly 3 invalid cycles.
  - The next valid instruction has `fetch_pc` = 0x85, with no duplicate and no skip.
- Relative redirect with `fetch_pc` = 0x8E and offset 8'hFA (−6). Required:
  - PC = 0x88 next cycle.
  - The following cycle has `fetch_valid` = 0.
  - Then `fetch_pc` = 0x88 valid.
- Absolute redirect to 0x20, outside the window. Required:
  - `fault` = 1 and `halted` = 1 next cycle.
  - PC unchanged.
  - No further valid fetches until reset.
- `redirect` and `stall` asserted together, target 0x90. Required: PC = 0x90 on the next edge.
- `reset` asserted (0) for 1 cycle mid-run at PC = 0x93. Required:
  - PC = 0x80, `fetch_valid` = 0, `fault` and `halted` clear on the next edge.
  - Normal fetch resumes afterwards.
